fir_tap_sequencer: RTL

Drives the shared 1-adder/1-multiplier MAC engine (`fir_1a1m`) for an 11-tap FIR. It accepts input samples on a valid/ready stream, keeps the 11-deep sample history and the 11-entry coefficient store, and presents one (sample, coefficient) pair per cycle to the engine. When the engine signals done it captures the engine's sum and returns it on an output valid/ready stream. It sits between the host-side data/coefficient interfaces and the engine.

---
 rtl/fir_tap_sequencer.sv | 90 +++++++++
 1 files changed

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: feeds one (sample, coefficient) pair per cycle to the shared MAC engine of an 11-tap FIR
module fir_tap_sequencer #(
    parameter int NTAP = 11,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          coef_we,
    input  logic [3:0]    coef_addr,
    input  logic [DW-1:0] coef_wdata,
    input  logic          ss_tvalid,
    input  logic [DW-1:0] ss_tdata,
    output logic          ss_tready,
    output logic          sm_tvalid,
    output logic [DW-1:0] sm_tdata,
    input  logic          sm_tready,
    output logic [DW-1:0] mac_x,
    output logic [DW-1:0] mac_coe,
    output logic          mac_valid,
    input  logic [DW-1:0] mac_y,
    input  logic          mac_done,
    output logic          busy,
    output logic          proto_err
);
    typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;
    localparam logic [3:0] KLAST = 4'(NTAP);
    state_t state;
    logic [DW-1:0] dbuf [NTAP];
    logic [DW-1:0] coef [NTAP];
    logic [DW-1:0] result;
    logic [3:0] k;
    logic [3:0] nk;
    assign nk = k + 4'd1;
    assign ss_tready = state == IDLE;
    assign sm_tdata = result;
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NTAP; i++) coef[i] <= '0;
        end else if (coef_we && !busy && coef_addr < KLAST) begin
            coef[coef_addr] <= coef_wdata;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            k <= '0;
            for (int i = 0; i < NTAP; i++) dbuf[i] <= '0;
            result <= '0;
            mac_x <= '0;
            mac_coe <= '0;
            mac_valid <= 1'b0;
            sm_tvalid <= 1'b0;
            busy <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (ss_tvalid) begin
                    for (int i = 1; i < NTAP; i++) dbuf[i] <= dbuf[i-1];
                    dbuf[0] <= ss_tdata;
                    k <= '0;
                    mac_x <= ss_tdata;
                    mac_coe <= coef[0];
                    mac_valid <= 1'b1;
                    busy <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    // done must arrive exactly on the trailing zero cycle
                    if (mac_done != (k == KLAST)) proto_err <= 1'b1;
                    if (k == KLAST) begin
                        result <= mac_y;
                        mac_valid <= 1'b0;
                        sm_tvalid <= 1'b1;
                        state <= OUT;
                    end else begin
                        k <= nk;
                        mac_x <= nk < KLAST ? dbuf[nk] : '0;
                        mac_coe <= nk < KLAST ? coef[nk] : '0;
                    end
                end
                OUT: if (sm_tready) begin
                    sm_tvalid <= 1'b0;
                    busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
